muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide engine for the MIPS core's MULT, MULTU, DIV and DIVU instructions. It sits directly upstream of the HI and LO `reg32` registers. Its `hi`/`lo` outputs drive their `writedata`, and `hilo_wen` drives their `wen`. Operands come from the register-file read ports in the same cycle that `start` is asserted.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`. Only 32 is required to be supported.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  32  multiplicand / dividend (rs)
- `b`  in  32  multiplier / divisor (rt)
- `cancel`  in  1  synchronous abort (pipeline flush)
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `hilo_wen`  out  1  write enable to the HI/LO registers; identical to `done`
- `hi`  out  32  product[63:32] or remainder
- `lo`  out  32  product[31:0] or quotient

## Operation
- FSM states:
  - IDLE: waiting for `start`.
  - RUN: 32 iterations, tracked by a 5-bit iteration counter.
  - DONE: one cycle, drives the result.
- IDLE → RUN when `start=1` and `cancel=0`.
  - On that edge, latch `op`.
  - For signed ops (MULT, DIV), latch the magnitudes |a| and |b|, taken mod 2^32, plus the result sign flags.
- RUN: one step per cycle.
  - Multiply: shift-add. Each step adds the multiplicand when the current multiplier LSB is 1, then shifts the 64-bit accumulator right by one.
  - Divide: restoring. Each step shifts the remainder left by one, brings in the next dividend bit, and subtracts the divisor when the remainder is ≥ divisor, setting the quotient bit.
- RUN → DONE after the 32nd step. On entry to DONE, apply sign correction:
  - Multiply: negate the 64-bit product when the operand signs differ (signed op only).
  - Divide: the quotient sign is the XOR of the operand signs. The remainder sign follows the dividend.
- DONE → IDLE unconditionally.
- `hi` and `lo` update only on entry to DONE. They hold their value until the next completed operation.
- Divide by zero (`b=0`, DIV or DIVU): `lo=32'hFFFFFFFF`, `hi=a` unmodified. Latency is the same as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: `lo=32'h80000000`, `hi=0`. This falls out of the mod-2^32 magnitudes; no special case is needed.
- Cancel:
  - `cancel=1` in RUN returns the FSM to IDLE on the next edge.
  - No `done`, `hilo_wen` stays 0, and `hi`/`lo` are unchanged.
  - `cancel` in DONE is ignored; the write still happens.
- `start` while `busy` is ignored and is not queued.
- `start` and `cancel` together in IDLE: cancel wins and nothing starts.

## Timing
- `start` is sampled at rising edge k. RUN occupies cycles k+1 … k+32, DONE is cycle k+33, and IDLE resumes at k+34.
- `busy` is high from after edge k through the end of cycle k+33.
- `done` and `hilo_wen` are high for exactly cycle k+33, with `hi`/`lo` already valid. The HI/LO registers capture them at edge k+34.
- The earliest back-to-back `start` is sampled at edge k+34, giving a throughput of one operation per 34 cycles.
- Reset (`reset=0`), effective immediately and asynchronously, in any state, including mid-RUN:
  - state = IDLE, counter = 0
  - `busy=0`, `done=0`, `hilo_wen=0`, `hi=0`, `lo=0`
  - all internal accumulators cleared
- `a`, `b` and `op` are don't-care after edge k.

## Structure
- Shared header `muldiv_defs.vh` holds:
  - the op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`)
  - the FSM state encodings
  - the decode constants used by the ALU control for HI/LO instructions
- One sub-module: `addsub33`, a 33-bit adder/subtractor with carry/borrow out. It is shared by the multiply add step and the divide trial subtraction.
- The FSM, counter and datapath registers live in `muldiv_unit`.

## Test plan
1. MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF → `hi=0xFFFFFFFE`, `lo=0x00000001`, with `done` exactly 33 cycles after the start edge and `busy` high throughout.
2. MULT with a=0xFFFFFFFD (−3), b=7 → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`. Follow with MULT 0x80000000 × 0x80000000 → `hi=0x40000000`, `lo=0`.
3. Divides with a=7 (0x00000007 / 0xFFFFFFF9), b=2:
   - DIV −7/2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
   - DIVU 7/2 → `lo=3`, `hi=1`.
4. Edge divides:
   - DIV 0x12345678 / 0 → `lo=0xFFFFFFFF`, `hi=0x12345678`.
   - DIV 0x80000000 / 0xFFFFFFFF → `lo=0x80000000`, `hi=0`.
5. Control hazards:
   - Pulse `start` again at RUN cycle 5: ignored, and the result matches the first op.
   - `cancel` at RUN cycle 10: `busy` drops the next cycle, there is no `done`/`hilo_wen`, and `hi`/`lo` keep their prior values.
6. Assert `reset` low mid-RUN (cycle 20) → `busy`, `done`, `hilo_wen`, `hi` and `lo` are all 0 immediately. A new MULTU 3×5 after release yields `lo=15`, `hi=0`.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op and FSM encodings for the multiply/divide unit, plus
// the ALU-control funct codes for the HI/LO instruction group.
package muldiv_unit_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction
endpackage

// File: rtl/muldiv_unit_addsub33.sv
// addsub33: adder/subtractor with carry out; when subtracting, cout=1 means no borrow.
module addsub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, x} + {1'b0, sub ? ~y : y} + {{W{1'b0}}, sub};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide for MULT, MULTU,
// DIV and DIVU, one step per cycle, feeding the HI/LO registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             hilo_wen,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d, asgn_q, asgn_d, dz_q, dz_d;
    logic [WIDTH-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
    logic [WIDTH:0]     ax, ay, sum;
    logic [WIDTH-1:0]   amag, quo, rem;
    logic               cout, div_op;

    // Upper half of acc is the partial product / remainder, lower half holds
    // the multiplier or dividend bits and fills with product / quotient bits.
    assign div_op = op_is_div(op_q);
    assign ax     = div_op ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign ay     = {1'b0, opb_q};

    addsub33 #(.W(WIDTH + 1)) u_addsub (
        .x    (ax),
        .y    (ay),
        .sub  (div_op),
        .s    (sum),
        .cout (cout)
    );

    assign step = div_op ? (cout ? {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                 : {ax[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0})
                         : (acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]});
    assign prod = neg_q ? -step : step;
    assign quo  = dz_q ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
    assign rem  = asgn_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    assign amag = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        asgn_d  = asgn_q;
        dz_d    = dz_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: if (start && !cancel) begin
                state_d = S_RUN;
                cnt_d   = '0;
                op_d    = op;
                neg_d   = op_is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
                asgn_d  = op_is_signed(op) && a[WIDTH-1];
                dz_d    = (b == '0);
                opb_d   = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;
                acc_d   = {{WIDTH{1'b0}}, amag};
            end
            S_RUN: if (cancel) begin
                state_d = S_IDLE;
            end else begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    hi_d    = div_op ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d    = div_op ? quo : prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            asgn_q  <= 1'b0;
            dz_q    <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            asgn_q  <= asgn_d;
            dz_q    <= dz_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign hilo_wen = done;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with literal expectations, plus an
// arithmetic reference model checked against the DUT every cycle.
module tb_muldiv_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, hilo_wen;
    logic [31:0] hi, lo;
    int          n_cmp = 0, n_bad = 0;
    int          phase = 0;
    logic [63:0] pend = '0, exp_hl = '0;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hilo_wen (hilo_wen),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {hi, lo} from plain arithmetic on the operands.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [31:0] mx, my, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (o == 2'd0) return sx * sy;
        if (o == 2'd1) return {32'd0, x} * {32'd0, y};
        if (y == 0) return {x, 32'hFFFFFFFF};
        mx = (o == 2'd2 && x[31]) ? -x : x;
        my = (o == 2'd2 && y[31]) ? -y : y;
        q = mx / my;
        r = mx % my;
        if (o == 2'd2 && (x[31] ^ y[31])) q = -q;
        if (o == 2'd2 && x[31]) r = -r;
        return {r, q};
    endfunction

    // phase 0 idle, 1..32 run steps, 33 the completion cycle
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase  <= 0;
            exp_hl <= '0;
        end else if (phase == 0) begin
            if (start && !cancel) begin
                phase <= 1;
                pend  <= ref_op(op, a, b);
            end
        end else if (phase == 33) begin
            phase <= 0;
        end else if (cancel) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
            if (phase == 32) exp_hl <= pend;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("m_busy", busy, phase != 0);
            check("m_done", done, phase == 33);
            check("m_wen", hilo_wen, phase == 33);
            check("m_hi", hi, exp_hl[63:32]);
            check("m_lo", lo, exp_hl[31:0]);
        end
    end

    // mode: 0 plain, 1 extra start in RUN, 2 cancel in RUN, 3 reset in RUN
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input int mode);
        int n = 0;
        bit seen = 0, dropped = 0;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == 5) begin start = 1'b1; op = 2'd1; a = 32'hDEAD; b = 32'hBEEF; end
            if (mode == 1 && n == 6) start = 1'b0;
            if (mode == 2 && n == 10) cancel = 1'b1;
            if (mode == 2 && n == 11) begin
                cancel = 1'b0;
                check("cancel_busy", busy, 0);
            end
            if (mode == 3 && n == 20) begin
                #2 reset = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done_wen", {done, hilo_wen}, 0);
                check("rst_hilo", {hi, lo}, 0);
                @(posedge clk); #1 reset = 1'b1;
                return;
            end
            if (done) begin seen = 1; break; end
            if (!busy) dropped = 1;
        end
        if (mode == 2) begin
            check("cancel_no_done", seen, 0);
            check("cancel_hilo", {hi, lo}, {ehi, elo});
        end else begin
            check("latency", n, 33);
            check("busy_through", dropped, 0);
            check("wen_at_done", hilo_wen, 1);
            check("hilo", {hi, lo}, {ehi, elo});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #11;
        check("reset_busy", busy, 0);
        check("reset_done_wen", {done, hilo_wen}, 0);
        check("reset_hilo", {hi, lo}, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        do_op(2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        do_op(2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
        do_op(2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        do_op(2'd3, 32'd7,        32'd2,        32'd1,        32'd3,        0);
        do_op(2'd2, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 0);
        do_op(2'd2, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 0);
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        do_op(2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1);
        start = 1'b1; cancel = 1'b1; op = 2'd1; a = 32'd4; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check("start_cancel_idle", busy, 0);
        @(posedge clk); #1;
        do_op(2'd0, 32'd5, 32'd6, 32'd2, 32'd14, 2);
        do_op(2'd1, 32'd9, 32'd9, 32'd0, 32'd81, 3);
        do_op(2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
